// File: rtl/stack_pkg.sv
// Shared types and modulo-DEPTH pointer helpers for the parametrised LIFO stack.
// DEPTH need not be a power of two, so wrapping is done by compare-and-adjust.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } command_t;

  // Callers keep ptr < depth and inc < depth, so one subtraction is enough.
  function automatic int wrap_add(input int ptr, input int inc, input int depth);
    int sum;
    sum = ptr + inc;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

  // dec may reach 2*depth-1 (an index one bit wider than needed), hence the first reduction.
  function automatic int wrap_dec(input int ptr, input int dec, input int depth);
    int d;
    d = dec;
    if (d >= depth) d = d - depth;
    if (ptr >= d) return ptr - d;
    return ptr + depth - d;
  endfunction

endpackage

// File: rtl/stack_param_if.sv
// Command/status bundle between a controller and the stack.
// The shared data bus stays a separate inout port on the stack.
interface stack_param_if import stack_pkg::*; #(
  parameter int DEPTH = 5
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  command_t        command;
  logic [IW-1:0]   index;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            err;

  modport master (
    output command,
    output index,
    input  count,
    input  full,
    input  empty,
    input  err
  );

  modport slave (
    input  command,
    input  index,
    output count,
    output full,
    output empty,
    output err
  );

endinterface

// File: rtl/stack_ring_mem.sv
// Ring of DEPTH words: synchronous write, combinational pointer-addressed read.
// Reset clears every word so stale reads after reset are deterministic zeros.
module stack_ring_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack on a shared tri-state bus, with ring (WRAP=1) or
// strict bounded (WRAP=0) behaviour at the full/empty limits.
module stack_param import stack_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  stack_param_if.slave     bus,
  inout  wire [WIDTH-1:0]  io_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [IW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t             top_q, top_d;
  cnt_t             count_q, count_d;
  logic             err_q, err_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic             wr_en;
  ptr_t             top_inc, top_dec, get_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             is_full, is_empty, index_ok;

  assign is_full  = (count_q == cnt_t'(DEPTH));
  assign is_empty = (count_q == '0);
  assign top_inc  = ptr_t'(wrap_add(int'(top_q), 1, DEPTH));
  assign top_dec  = ptr_t'(wrap_dec(int'(top_q), 1, DEPTH));
  assign get_ptr  = ptr_t'(wrap_dec(int'(top_dec), int'(bus.index), DEPTH));
  assign index_ok = (int'(bus.index) < int'(count_q));
  assign rd_ptr   = (bus.command == CMD_GET) ? get_ptr : top_dec;

  stack_ring_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_ptr  (top_q),
    .wr_data (io_data),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    err_d   = 1'b0;
    oe_d    = 1'b0;
    out_d   = '0;
    wr_en   = 1'b0;
    case (bus.command)
      CMD_PUSH: begin
        if (!is_full) begin
          wr_en   = 1'b1;
          top_d   = top_inc;
          count_d = count_q + 1'b1;
        end else if (WRAP) begin
          wr_en = 1'b1;
          top_d = top_inc;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_POP: begin
        oe_d = 1'b1;
        if (!is_empty) begin
          out_d   = rd_data;
          top_d   = top_dec;
          count_d = count_q - 1'b1;
        end else if (WRAP) begin
          // Legacy ring behaviour: keep walking down and expose stale contents.
          out_d = rd_data;
          top_d = top_dec;
          err_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_GET: begin
        oe_d = 1'b1;
        if (WRAP || index_ok) out_d = rd_data;
        else                  err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
    end
  end

  // A presented PUSH means the controller owns the bus, so release it at once.
  assign io_data = (oe_q && (bus.command != CMD_PUSH)) ? out_q : {WIDTH{1'bz}};

  assign bus.count = count_q;
  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_stack_param.sv
// Directed bench for stack_param: ring mode (A), strict mode (B) and a
// non-power-of-two depth (C). Buses are tri1, so a released bus reads all-ones.
module tb_stack_param;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_param_if #(.DEPTH(5)) if_a ();
  stack_param_if #(.DEPTH(5)) if_b ();
  stack_param_if #(.DEPTH(6)) if_c ();

  tri1 [3:0] bus_a;
  tri1 [3:0] bus_b;
  tri1 [7:0] bus_c;

  logic [7:0] drv;
  int         drive_sel;
  int         tests;
  int         fails;

  assign bus_a = (drive_sel == 1) ? drv[3:0] : 4'bzzzz;
  assign bus_b = (drive_sel == 2) ? drv[3:0] : 4'bzzzz;
  assign bus_c = (drive_sel == 3) ? drv      : 8'bzzzzzzzz;

  stack_param #(.WIDTH(4), .DEPTH(5), .WRAP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .io_data(bus_a));
  stack_param #(.WIDTH(4), .DEPTH(5), .WRAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .io_data(bus_b));
  stack_param #(.WIDTH(8), .DEPTH(6), .WRAP(1'b1)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c), .io_data(bus_c));

  // which: 0 = A, 1 = B, 2 = C; the other two stacks idle on NOP.
  task automatic apply_stimulus(input int which, input command_t cmd,
                                input logic [2:0] idx, input logic [7:0] data,
                                input logic rst);
    reset = rst;
    if_a.command = CMD_NOP;
    if_b.command = CMD_NOP;
    if_c.command = CMD_NOP;
    if_a.index = idx;
    if_b.index = idx;
    if_c.index = idx;
    case (which)
      0:       if_a.command = cmd;
      1:       if_b.command = cmd;
      default: if_c.command = cmd;
    endcase
    drv = data;
    drive_sel = (cmd == CMD_PUSH) ? which + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drv = '0;
    drive_sel = 0;
    reset = 1'b1;
    if_a.command = CMD_NOP; if_a.index = '0;
    if_b.command = CMD_NOP; if_b.index = '0;
    if_c.command = CMD_NOP; if_c.index = '0;

    apply_stimulus(0, CMD_NOP, 3'd0, 8'h00, 1'b1);
    apply_stimulus(0, CMD_NOP, 3'd0, 8'h00, 1'b1);
    check_output("rst_a_count", {5'h0, if_a.count}, 8'd0);
    check_output("rst_a_empty", {7'h0, if_a.empty}, 8'd1);
    check_output("rst_a_full",  {7'h0, if_a.full},  8'd0);
    check_output("rst_a_err",   {7'h0, if_a.err},   8'd0);
    check_output("rst_a_bus",   {4'h0, bus_a},      8'h0F);
    check_output("rst_b_count", {5'h0, if_b.count}, 8'd0);
    check_output("rst_c_count", {5'h0, if_c.count}, 8'd0);
    check_output("rst_c_bus",   bus_c,              8'hFF);

    // A: ring mode, fill then read back by offset
    for (int i = 1; i <= 5; i++) apply_stimulus(0, CMD_PUSH, 3'd0, 8'(i), 1'b0);
    check_output("a_fill_count", {5'h0, if_a.count}, 8'd5);
    check_output("a_fill_full",  {7'h0, if_a.full},  8'd1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, CMD_GET, 3'(i), 8'h00, 1'b0);
      check_output($sformatf("a_get%0d", i), {4'h0, bus_a}, 8'(5 - i));
    end
    apply_stimulus(0, CMD_PUSH, 3'd0, 8'h06, 1'b0);
    check_output("a_wrap_count", {5'h0, if_a.count}, 8'd5);
    check_output("a_wrap_err",   {7'h0, if_a.err},   8'd0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, CMD_GET, 3'(i), 8'h00, 1'b0);
      check_output($sformatf("a_wget%0d", i), {4'h0, bus_a}, 8'(6 - i));
      check_output($sformatf("a_wget%0d_err", i), {7'h0, if_a.err}, 8'd0);
    end
    apply_stimulus(0, CMD_GET, 3'd5, 8'h00, 1'b0);
    check_output("a_get5_mod", {4'h0, bus_a}, 8'd6);
    apply_stimulus(0, CMD_NOP, 3'd0, 8'h00, 1'b0);
    check_output("a_nop_bus", {4'h0, bus_a}, 8'h0F);

    // B: strict mode, overflow and underflow
    for (int i = 1; i <= 5; i++) apply_stimulus(1, CMD_PUSH, 3'd0, 8'(i), 1'b0);
    apply_stimulus(1, CMD_PUSH, 3'd0, 8'h09, 1'b0);
    check_output("b_ovf_err",   {7'h0, if_b.err},   8'd1);
    check_output("b_ovf_count", {5'h0, if_b.count}, 8'd5);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, CMD_POP, 3'd0, 8'h00, 1'b0);
      check_output($sformatf("b_pop%0d", i), {4'h0, bus_b}, 8'(5 - i));
      check_output($sformatf("b_pop%0d_err", i), {7'h0, if_b.err}, 8'd0);
    end
    check_output("b_empty", {7'h0, if_b.empty}, 8'd1);
    apply_stimulus(1, CMD_POP, 3'd0, 8'h00, 1'b0);
    check_output("b_unf_bus",   {4'h0, bus_b},      8'd0);
    check_output("b_unf_err",   {7'h0, if_b.err},   8'd1);
    check_output("b_unf_count", {5'h0, if_b.count}, 8'd0);

    apply_stimulus(1, CMD_PUSH, 3'd0, 8'h07, 1'b0);
    apply_stimulus(1, CMD_PUSH, 3'd0, 8'h08, 1'b0);
    check_output("b_push_count", {5'h0, if_b.count}, 8'd2);
    apply_stimulus(1, CMD_GET, 3'd2, 8'h00, 1'b0);
    check_output("b_get2_bus", {4'h0, bus_b},    8'd0);
    check_output("b_get2_err", {7'h0, if_b.err}, 8'd1);
    apply_stimulus(1, CMD_GET, 3'd1, 8'h00, 1'b0);
    check_output("b_get1_bus", {4'h0, bus_b},    8'd7);
    check_output("b_get1_err", {7'h0, if_b.err}, 8'd0);
    apply_stimulus(1, CMD_NOP, 3'd0, 8'h00, 1'b0);
    check_output("b_nop_bus",   {4'h0, bus_b},      8'h0F);
    check_output("b_nop_count", {5'h0, if_b.count}, 8'd2);

    // B: reset wins over a POP on the same edge
    for (int i = 3; i <= 5; i++) apply_stimulus(1, CMD_PUSH, 3'd0, 8'(i), 1'b0);
    check_output("b_pre_rst_count", {5'h0, if_b.count}, 8'd5);
    apply_stimulus(1, CMD_POP, 3'd0, 8'h00, 1'b1);
    check_output("b_rst_bus",   {4'h0, bus_b},      8'h0F);
    check_output("b_rst_count", {5'h0, if_b.count}, 8'd0);
    apply_stimulus(1, CMD_POP, 3'd0, 8'h00, 1'b0);
    check_output("b_rst_pop_bus", {4'h0, bus_b},    8'd0);
    check_output("b_rst_pop_err", {7'h0, if_b.err}, 8'd1);

    // C: DEPTH=6 ring, overfill by two then drain
    for (int i = 0; i < 8; i++) apply_stimulus(2, CMD_PUSH, 3'd0, 8'(8'h10 + i), 1'b0);
    check_output("c_fill_count", {5'h0, if_c.count}, 8'd6);
    check_output("c_fill_full",  {7'h0, if_c.full},  8'd1);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(2, CMD_POP, 3'd0, 8'h00, 1'b0);
      check_output($sformatf("c_pop%0d", i), bus_c, 8'(8'h17 - i));
    end
    check_output("c_drain_count", {5'h0, if_c.count}, 8'd0);
    check_output("c_drain_empty", {7'h0, if_c.empty}, 8'd1);
    apply_stimulus(2, CMD_PUSH, 3'd0, 8'hAA, 1'b0);
    apply_stimulus(2, CMD_GET, 3'd0, 8'h00, 1'b0);
    check_output("c_get0_aa",   bus_c,              8'hAA);
    check_output("c_aa_count",  {5'h0, if_c.count}, 8'd1);
    apply_stimulus(2, CMD_POP, 3'd0, 8'h00, 1'b0);
    check_output("c_pop_aa", bus_c, 8'hAA);
    // Empty pop in ring mode exposes the stale word just below (0x17 in slot 1).
    apply_stimulus(2, CMD_POP, 3'd0, 8'h00, 1'b0);
    check_output("c_stale_bus",   bus_c,              8'h17);
    check_output("c_stale_err",   {7'h0, if_c.err},   8'd1);
    check_output("c_stale_count", {5'h0, if_c.count}, 8'd0);

    apply_stimulus(0, CMD_NOP, 3'd0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
